// File: rtl/icb_reg_sram_bridge.sv
// ICB slave: byte-maskable CSRs, self-clearing command pulses, status word and a 64-bit SRAM window.
// Define ICB_SLV_ERR_EN to flag unmapped or illegal accesses on icb_rsp_err.
module icb_reg_sram_bridge #(
  parameter int NUM_CSR   = 4,
  parameter int NUM_BANKS = 4,
  parameter int SRAM_AW   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     icb_cmd_valid,
  output logic                     icb_cmd_ready,
  input  logic                     icb_cmd_read,
  input  logic [31:0]              icb_cmd_addr,
  input  logic [31:0]              icb_cmd_wdata,
  input  logic [3:0]               icb_cmd_wmask,
  output logic                     icb_rsp_valid,
  input  logic                     icb_rsp_ready,
  output logic [31:0]              icb_rsp_rdata,
  output logic                     icb_rsp_err,
  output logic [NUM_CSR*32-1:0]    csr_q,
  output logic [31:0]              cmd_pulse,
  input  logic [31:0]              status_i,
  output logic [NUM_BANKS-1:0]     sram_csb,
  output logic                     sram_web,
  output logic [SRAM_AW-1:0]       sram_addr,
  output logic [63:0]              sram_wdata,
  output logic [7:0]               sram_wben,
  input  logic [NUM_BANKS*64-1:0]  sram_rdata,
  output logic [1:0]               dbg_state
);

  localparam int         BIW      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [8:0] CSR_LAST = 9'(NUM_CSR);
  localparam logic [8:0] STAT_IDX = 9'(NUM_CSR + 1);
  localparam logic [10:0] NB      = 11'(NUM_BANKS);

  typedef enum logic [1:0] {IDLE = 2'd0, SRD = 2'd1, RSP = 2'd2} state_t;

  // Handshake: a command is taken on the edge where icb_cmd_valid && icb_cmd_ready;
  // a response is retired on the edge where icb_rsp_valid && icb_rsp_ready, and
  // icb_rsp_valid/icb_rsp_rdata/icb_rsp_err hold until then.
  state_t             state;
  logic               cmd_ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic [31:0]        csr_r [NUM_CSR];
  logic               lo_vld;
  logic [31:0]        hold_data;
  logic [3:0]         hold_mask;
  logic [7:0]         hold_addr;
  logic [BIW-1:0]     rd_bank;
  logic               rd_half;
  logic               rd_hit;

  logic [11:0]        off;
  logic               accept;
  logic               is_sram;
  logic [8:0]         csr_idx;
  logic [10:0]        bank_full;
  logic [BIW-1:0]     bank;
  logic [SRAM_AW-1:0] word;
  logic               half;
  logic               bank_ok;
  logic               is_cmd;
  logic               is_stat;
  logic [31:0]        mask32;
  logic               sram_wr;
  logic               sram_rd;
  logic               lo_match;
  logic [31:0]        csr_rd;
  logic [31:0]        srd_data;
  logic               unused_addr;

  assign off       = icb_cmd_addr[11:0];
  assign accept    = icb_cmd_valid & cmd_ready_q;
  assign is_sram   = off[11];
  assign csr_idx   = off[10:2];
  assign bank_full = off[10:0] >> (SRAM_AW + 3);
  assign bank      = bank_full[BIW-1:0];
  assign word      = off[SRAM_AW+2:3];
  assign half      = off[2];
  assign bank_ok   = is_sram && (bank_full < NB);
  assign is_cmd    = !is_sram && (csr_idx == 9'd0);
  assign is_stat   = !is_sram && (csr_idx == STAT_IDX);
  assign mask32    = {{8{icb_cmd_wmask[3]}}, {8{icb_cmd_wmask[2]}},
                      {8{icb_cmd_wmask[1]}}, {8{icb_cmd_wmask[0]}}};
  // Only the high-half write touches the array; the low half waits in the hold register.
  assign sram_wr   = accept && bank_ok && !icb_cmd_read && half;
  assign sram_rd   = accept && bank_ok && icb_cmd_read;
  assign lo_match  = lo_vld && (hold_addr == off[10:3]);
  assign unused_addr = ^icb_cmd_addr[31:12];

  assign icb_cmd_ready = cmd_ready_q;
  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign dbg_state     = state;

  genvar g;
  generate
    for (g = 0; g < NUM_CSR; g++) begin : g_csr_q
      assign csr_q[g*32 +: 32] = csr_r[g];
    end
  endgenerate

  always_comb begin
    csr_rd = '0;
    if (is_stat) csr_rd = status_i;
    for (int i = 0; i < NUM_CSR; i++) begin
      if (!is_sram && csr_idx == 9'(i + 1)) csr_rd = csr_r[i];
    end
  end

  always_comb begin
    srd_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_hit && rd_bank == BIW'(b))
        srd_data = rd_half ? sram_rdata[b*64+32 +: 32] : sram_rdata[b*64 +: 32];
    end
  end

  always_comb begin
    sram_csb = '1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if ((sram_wr || sram_rd) && bank == BIW'(b)) sram_csb[b] = 1'b0;
    end
    sram_web   = !sram_wr;
    sram_addr  = word;
    sram_wdata = {icb_cmd_wdata, hold_data};
    sram_wben  = sram_wr ? {icb_cmd_wmask, (lo_match ? hold_mask : 4'h0)} : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cmd_pulse   <= '0;
      lo_vld      <= 1'b0;
      hold_data   <= '0;
      hold_mask   <= '0;
      hold_addr   <= '0;
      rd_bank     <= '0;
      rd_half     <= 1'b0;
      rd_hit      <= 1'b0;
      for (int i = 0; i < NUM_CSR; i++) csr_r[i] <= '0;
    end else begin
      cmd_pulse <= '0;
      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            if (is_sram && icb_cmd_read) begin
              state   <= SRD;
              rd_bank <= bank;
              rd_half <= half;
              rd_hit  <= bank_ok;
            end else begin
              state       <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= icb_cmd_read ? csr_rd : 32'h0;
            end
            if (!icb_cmd_read) begin
              if (is_cmd) cmd_pulse <= icb_cmd_wdata & mask32;
              for (int i = 0; i < NUM_CSR; i++) begin
                if (!is_sram && csr_idx == 9'(i + 1))
                  csr_r[i] <= (csr_r[i] & ~mask32) | (icb_cmd_wdata & mask32);
              end
              if (bank_ok) begin
                if (!half) begin
                  hold_data <= icb_cmd_wdata;
                  hold_mask <= icb_cmd_wmask;
                  hold_addr <= off[10:3];
                  lo_vld    <= 1'b1;
                end else begin
                  lo_vld    <= 1'b0;
                end
              end
            end
          end
        end
        SRD: begin
          rsp_rdata_q <= srd_data;
          rsp_valid_q <= 1'b1;
          state       <= RSP;
        end
        RSP: begin
          if (icb_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICB_SLV_ERR_EN
  logic err_d;
  logic rsp_err_q;
  assign err_d = (!is_sram && csr_idx > STAT_IDX) || (is_sram && !bank_ok) ||
                 (!icb_cmd_read && is_stat) || (icb_cmd_read && is_cmd);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        rsp_err_q <= 1'b0;
    else if (state == IDLE && accept)  rsp_err_q <= err_d;
  end
  assign icb_rsp_err = rsp_err_q;
`else
  assign icb_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_icb_reg_sram_bridge.sv
// Bench for icb_reg_sram_bridge: random ICB traffic against a spec-level model, scoreboard queue
// checked by a monitor; behavioural SRAM banks attached. Honors ICB_SLV_ERR_EN like the design.
module tb_icb_reg_sram_bridge;
  localparam int NUM_CSR = 4, NUM_BANKS = 4, SRAM_AW = 6;
  localparam int NW = 1 << SRAM_AW;

  logic clk, rst_n;
  logic icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0] icb_cmd_wmask;
  logic icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [31:0] icb_rsp_rdata, cmd_pulse, status_i;
  logic [NUM_CSR*32-1:0] csr_q;
  logic [NUM_BANKS-1:0] sram_csb;
  logic sram_web;
  logic [SRAM_AW-1:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [7:0] sram_wben;
  logic [NUM_BANKS*64-1:0] sram_rdata;
  logic [1:0] dbg_state;

  icb_reg_sram_bridge #(.NUM_CSR(NUM_CSR), .NUM_BANKS(NUM_BANKS), .SRAM_AW(SRAM_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err), .csr_q(csr_q), .cmd_pulse(cmd_pulse), .status_i(status_i),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wben(sram_wben), .sram_rdata(sram_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural SRAM banks
  logic [63:0] mem [NUM_BANKS][NW];
  logic [63:0] srd [NUM_BANKS];
  genvar gb;
  generate
    for (gb = 0; gb < NUM_BANKS; gb++) begin : g_rd
      assign sram_rdata[gb*64 +: 64] = srd[gb];
    end
  endgenerate
  always @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!sram_csb[b]) begin
        if (!sram_web) begin
          for (int k = 0; k < 8; k++)
            if (sram_wben[k]) mem[b][sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
        end else begin
          srd[b] <= mem[b][sram_addr];
        end
      end
    end
  end

  // reference model state
  logic [31:0] ref_csr [NUM_CSR];
  logic [63:0] ref_mem [NUM_BANKS][NW];
  logic        m_lo_vld;
  logic [31:0] m_hold_data;
  logic [3:0]  m_hold_mask;
  int          m_hold_bank, m_hold_word;

  // scoreboard
  logic [34:0] exp_q [$];
  int n_vec = 0, n_bad = 0;
  int acc_cyc = 0, pulse_cyc = -1;
  logic [31:0] pulse_val = '0;
  int stall_cnt = 0;
  bit mon_en = 0, pending = 0;
  logic [31:0] held_rdata;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // monitor: drives rsp_ready, pops and compares responses
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_cnt > 0 && icb_rsp_valid) begin
        icb_rsp_ready = 1'b0;
        stall_cnt--;
      end else if (stall_cnt == 0) begin
        icb_rsp_ready = ($urandom_range(0, 3) != 0);
      end
      check("cmd_pulse", 64'(cmd_pulse), (cyc == pulse_cyc) ? 64'(pulse_val) : 64'h0);
      if (!icb_cmd_valid) begin
        check("idle_csb", 64'(sram_csb), 64'({NUM_BANKS{1'b1}}));
        check("idle_web", 64'(sram_web), 64'h1);
      end
      if (pending) begin
        check("rsp_valid_hold", 64'(icb_rsp_valid), 64'h1);
        check("rsp_rdata_hold", 64'(icb_rsp_rdata), 64'(held_rdata));
        check("cmd_ready_busy", 64'(icb_cmd_ready), 64'h0);
      end else if (icb_rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(icb_rsp_valid), 64'h0);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          check("rsp_rdata", 64'(icb_rsp_rdata), 64'(e[31:0]));
          check("rsp_err", 64'(icb_rsp_err), 64'(e[34]));
          check("rsp_latency", 64'(cyc - acc_cyc), 64'(e[33:32]));
          check("cmd_ready_busy", 64'(icb_cmd_ready), 64'h0);
          for (int i = 0; i < NUM_CSR; i++)
            check($sformatf("csr_q[%0d]", i + 1), 64'(csr_q[i*32 +: 32]), 64'(ref_csr[i]));
          held_rdata = icb_rsp_rdata;
          pending = 1;
        end
      end
      if (pending && icb_rsp_ready) pending = 0;
    end
  end

  // driver: issues one command and records the model's expected response
  task automatic do_txn(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] m);
    int n, off, idx, bank, word, half, lat;
    logic [31:0] rdat, m32;
    logic err;
    logic [7:0] wb;
    logic [63:0] wd;
    logic [NUM_BANKS-1:0] ecsb;
    @(negedge clk);
    status_i = $urandom;
    icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
    icb_cmd_wdata = wdata; icb_cmd_wmask = m;
    #1;
    n = 0;
    while (!icb_cmd_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!icb_cmd_ready) begin
      check("cmd_accept_timeout", 64'(icb_cmd_ready), 64'h1);
      icb_cmd_valid = 1'b0;
      return;
    end
    off = int'(addr[11:0]);
    m32 = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    rdat = '0; err = 1'b0; lat = 1; ecsb = '1;
    if (off < 2048) begin
      idx = off / 4;
      if (rd) begin
        if (idx >= 1 && idx <= NUM_CSR) rdat = ref_csr[idx-1];
        else if (idx == NUM_CSR + 1) rdat = status_i;
      end else begin
        if (idx == 0) begin pulse_val = wdata & m32; pulse_cyc = cyc + 1; end
        if (idx >= 1 && idx <= NUM_CSR) ref_csr[idx-1] = (ref_csr[idx-1] & ~m32) | (wdata & m32);
      end
`ifdef ICB_SLV_ERR_EN
      err = (idx > NUM_CSR + 1) || (!rd && idx == NUM_CSR + 1) || (rd && idx == 0);
`endif
      check("csr_acc_csb", 64'(sram_csb), 64'(ecsb));
      check("csr_acc_web", 64'(sram_web), 64'h1);
    end else begin
      bank = (off - 2048) / (8 * NW);
      word = (off / 8) % NW;
      half = (off / 4) % 2;
`ifdef ICB_SLV_ERR_EN
      err = (bank >= NUM_BANKS);
`endif
      if (rd) begin
        lat = 2;
        if (bank < NUM_BANKS) begin
          rdat = half ? ref_mem[bank][word][63:32] : ref_mem[bank][word][31:0];
          ecsb[bank] = 1'b0;
          check("rd_addr", 64'(sram_addr), 64'(word));
        end
        check("rd_csb", 64'(sram_csb), 64'(ecsb));
        check("rd_web", 64'(sram_web), 64'h1);
      end else if (bank < NUM_BANKS && half == 0) begin
        m_hold_data = wdata; m_hold_mask = m; m_hold_bank = bank; m_hold_word = word;
        m_lo_vld = 1'b1;
        check("lo_csb", 64'(sram_csb), 64'(ecsb));
      end else if (bank < NUM_BANKS) begin
        wb = {m, (m_lo_vld && m_hold_bank == bank && m_hold_word == word) ? m_hold_mask : 4'h0};
        wd = {wdata, m_hold_data};
        m_lo_vld = 1'b0;
        for (int k = 0; k < 8; k++) if (wb[k]) ref_mem[bank][word][8*k +: 8] = wd[8*k +: 8];
        ecsb[bank] = 1'b0;
        check("wr_csb", 64'(sram_csb), 64'(ecsb));
        check("wr_web", 64'(sram_web), 64'h0);
        check("wr_addr", 64'(sram_addr), 64'(word));
        check("wr_wdata", sram_wdata, wd);
        check("wr_wben", 64'(sram_wben), 64'(wb));
      end
    end
    exp_q.push_back({err, 2'(lat), rdat});
    acc_cyc = cyc;
    @(posedge clk);
    #1 icb_cmd_valid = 1'b0;
  endtask

  function automatic logic [31:0] sram_off(int bank, int word, int half);
    return 32'h800 | 32'(bank << (SRAM_AW + 3)) | 32'(word << 3) | 32'(half << 2);
  endfunction

  initial begin
    int r, b, w, h, n;
    logic [31:0] up;
    for (int i = 0; i < NUM_CSR; i++) ref_csr[i] = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      for (int j = 0; j < NW; j++) begin
        mem[i][j] = {$urandom, $urandom};
        ref_mem[i][j] = mem[i][j];
      end
    for (int i = 0; i < NUM_BANKS; i++) srd[i] = '0;
    m_lo_vld = 0; m_hold_data = '0; m_hold_mask = '0; m_hold_bank = 0; m_hold_word = 0;
    rst_n = 1'b0; icb_cmd_valid = 0; icb_cmd_read = 0; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_ready = 1'b1; status_i = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(icb_cmd_ready), 64'h0);
    check("rst_rsp_valid", 64'(icb_rsp_valid), 64'h0);
    check("rst_rsp_rdata", 64'(icb_rsp_rdata), 64'h0);
    check("rst_rsp_err", 64'(icb_rsp_err), 64'h0);
    check("rst_csr_q", 64'(csr_q[63:0]) | 64'(csr_q[NUM_CSR*32-1:64]), 64'h0);
    check("rst_cmd_pulse", 64'(cmd_pulse), 64'h0);
    check("rst_csb", 64'(sram_csb), 64'({NUM_BANKS{1'b1}}));
    check("rst_web", 64'(sram_web), 64'h1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", 64'(icb_cmd_ready), 64'h1);
    mon_en = 1;

    // directed cases
    do_txn(0, 32'h004, 32'hA5A5_1234, 4'b0011);
    do_txn(1, 32'h004, 32'h0, 4'h0);
    do_txn(0, 32'h000, 32'h0000_0081, 4'hF);
    do_txn(0, sram_off(1, 3, 0), 32'h1111_1111, 4'hF);
    do_txn(0, sram_off(1, 3, 1), 32'h2222_2222, 4'hF);
    do_txn(1, sram_off(1, 3, 1), 32'h0, 4'h0);
    do_txn(1, sram_off(1, 3, 0), 32'h0, 4'h0);
    do_txn(0, sram_off(0, 1, 1), 32'hDEAD_BEEF, 4'hF);
    do_txn(1, sram_off(0, 1, 1), 32'h0, 4'h0);
    stall_cnt = 5;
    do_txn(1, 32'h004, 32'h0, 4'h0);
    do_txn(1, 32'h4 * (NUM_CSR + 2), 32'h0, 4'h0);
    do_txn(1, 32'h4 * (NUM_CSR + 1), 32'h0, 4'h0);
    do_txn(0, 32'h4 * (NUM_CSR + 1), 32'hFFFF_FFFF, 4'hF);
    do_txn(1, 32'h000, 32'h0, 4'h0);

    // random traffic
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      up = $urandom & 32'hFFFF_F000;
      if (r < 4) begin
        n = $urandom_range(0, NUM_CSR + 3);
        do_txn($urandom_range(0, 2) == 0, up | 32'(n * 4), $urandom, 4'($urandom_range(0, 15)));
      end else begin
        b = $urandom_range(0, NUM_BANKS - 1); w = $urandom_range(0, 3); h = $urandom_range(0, 1);
        if (r == 9) begin
          do_txn(0, up | sram_off(b, w, 0), $urandom, 4'($urandom_range(0, 15)));
          do_txn(0, up | sram_off(b, w, 1), $urandom, 4'($urandom_range(0, 15)));
        end else begin
          do_txn($urandom_range(0, 2) == 0, up | sram_off(b, w, h), $urandom,
                 4'($urandom_range(0, 15)));
        end
      end
    end

    n = 0;
    while ((exp_q.size() != 0 || pending) && n < 100) begin @(negedge clk); n++; end
    check("drain_outstanding", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
